// File: rtl/period_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : period_control_pkg
// Description : Shared definitions for the period_control operator stage:
//               FSM state encoding, period limits and the active-low
//               7-segment hex decode (also reused by regressive_counter).
// Revision    : 1.0 - initial release
// ============================================================================
package period_control_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam logic [3:0] PERIOD_MIN = 4'd1;
  localparam logic [3:0] PERIOD_MAX = 4'd15;

  // Active-low segment image, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/period_control_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : Debounces one active-low push-button and emits a single-cycle
//               pulse when a press is accepted.
// Revision    : 1.0 - initial release
// Ports       : clock       - system clock
//               reset       - synchronous active-low reset
//               key_n       - raw asynchronous button, active-low
//               level       - accepted (debounced) key level, 1 = released
//               press_pulse - one-cycle pulse on accepted 1->0 transition
// ============================================================================
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] count;

  // The counter measures how long the synchronized key has disagreed with the
  // accepted level; any agreement restarts the measurement, so short bounces
  // never accumulate.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_1      <= 1'b1;
      sync_2      <= 1'b1;
      level       <= 1'b1;
      count       <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_1      <= key_n;
      sync_2      <= sync_1;
      press_pulse <= 1'b0;
      if (sync_2 == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        level       <= sync_2;
        count       <= '0;
        press_pulse <= ~sync_2;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/period_control.sv
`default_nettype none
// ============================================================================
// Module      : period_control
// Description : Operator input stage for regressive_counter. Debounces the
//               up/down/start keys, edits the countdown period while idle and
//               runs an IDLE/RUNNING/PAUSED control FSM.
// Revision    : 1.0 - initial release
// Ports       : clock          - 50 MHz system clock
//               reset          - synchronous active-low reset
//               key_up_n       - raw button, increments period (IDLE only)
//               key_down_n     - raw button, decrements period (IDLE only)
//               key_start_n    - raw button, start/pause toggle
//               finished       - end-of-countdown flag from regressive_counter
//               seconds_period - selected period, 1..15
//               start          - run level, 1 = count
//               hex4_period    - active-low 7-seg image of seconds_period
//               ledr8_running  - high while RUNNING
// ============================================================================
module period_control
  import period_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DEFAULT_PERIOD  = 5,
  parameter bit ONE_SHOT        = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_start_n,
  input  logic       finished,
  output logic [3:0] seconds_period,
  output logic       start,
  output logic [6:0] hex4_period,
  output logic       ledr8_running
);

  localparam logic [3:0] RESET_PERIOD = 4'(DEFAULT_PERIOD);

  logic [2:0] key_levels_unused;
  logic       up_press;
  logic       down_press;
  logic       start_press;

  state_t     state;
  state_t     next_state;
  logic [3:0] next_period;
  logic       run_q;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
    .clock       (clock),
    .reset       (reset),
    .key_n       (key_up_n),
    .level       (key_levels_unused[0]),
    .press_pulse (up_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
    .clock       (clock),
    .reset       (reset),
    .key_n       (key_down_n),
    .level       (key_levels_unused[1]),
    .press_pulse (down_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
    .clock       (clock),
    .reset       (reset),
    .key_n       (key_start_n),
    .level       (key_levels_unused[2]),
    .press_pulse (start_press)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      seconds_period <= RESET_PERIOD;
      hex4_period    <= hex7seg(RESET_PERIOD);
      run_q          <= 1'b0;
    end else begin
      state          <= next_state;
      seconds_period <= next_period;
      hex4_period    <= hex7seg(next_period);
      run_q          <= (next_state == RUNNING);
    end
  end

  // The period can only be edited from IDLE; the edit uses the state held
  // at the edge, so a start press and an edit press in the same cycle both
  // take effect.
  always_comb begin
    next_state  = state;
    next_period = seconds_period;
    case (state)
      IDLE: begin
        if (start_press) begin
          next_state = RUNNING;
        end
        if (up_press && !down_press && (seconds_period != PERIOD_MAX)) begin
          next_period = seconds_period + 4'd1;
        end else if (down_press && !up_press && (seconds_period != PERIOD_MIN)) begin
          next_period = seconds_period - 4'd1;
        end
      end
      RUNNING: begin
        // finished outranks a coincident start press in one-shot mode
        if (ONE_SHOT && finished) begin
          next_state = IDLE;
        end else if (start_press) begin
          next_state = PAUSED;
        end
      end
      PAUSED: begin
        if (start_press) begin
          next_state = RUNNING;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign start         = run_q;
  assign ledr8_running = run_q;

endmodule
`default_nettype wire

// File: tb/tb_period_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_period_control
// Description : Self-checking bench for period_control. Two instances share
//               all stimulus: dut_a with ONE_SHOT=1 and dut_b with ONE_SHOT=0.
//               Directed table plus hand sequences, followed by random keys,
//               finished pulses and resets against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_period_control;

  localparam int DEB     = 4;
  localparam int DEF_P   = 5;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic clock = 1'b0;
  always #10 clock = ~clock;

  logic       reset;
  logic       key_up_n;
  logic       key_down_n;
  logic       key_start_n;
  logic       finished;
  logic [3:0] per_a, per_b;
  logic       start_a, start_b;
  logic [6:0] hex_a, hex_b;
  logic       run_a, run_b;

  period_control #(.DEBOUNCE_CYCLES(DEB), .DEFAULT_PERIOD(DEF_P), .ONE_SHOT(1'b1)) dut_a (
    .clock          (clock),
    .reset          (reset),
    .key_up_n       (key_up_n),
    .key_down_n     (key_down_n),
    .key_start_n    (key_start_n),
    .finished       (finished),
    .seconds_period (per_a),
    .start          (start_a),
    .hex4_period    (hex_a),
    .ledr8_running  (run_a)
  );

  period_control #(.DEBOUNCE_CYCLES(DEB), .DEFAULT_PERIOD(DEF_P), .ONE_SHOT(1'b0)) dut_b (
    .clock          (clock),
    .reset          (reset),
    .key_up_n       (key_up_n),
    .key_down_n     (key_down_n),
    .key_start_n    (key_start_n),
    .finished       (finished),
    .seconds_period (per_b),
    .start          (start_b),
    .hex4_period    (hex_b),
    .ledr8_running  (run_b)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic [6:0] seg_ref [16];

  typedef struct {
    int op;          // 0 up, 1 down, 2 start, 3 finished pulse
    int reps;
    int exp_period;
    int exp_start;
  } vec_t;
  vec_t tbl [9];

  // ---------------- behavioural reference model ----------------
  int m_state  [2];
  int m_period [2];
  bit m_start  [2];
  bit m_hist0  [3];
  bit m_hist1  [3];
  bit m_lvl    [3];
  bit m_pulse  [3];
  int m_streak [3];
  bit raw      [3];
  int hold     [3];

  // A key is accepted once it has disagreed with the accepted level for DEB
  // consecutive samples, seen through a two-sample input delay. The FSM acts on
  // presses accepted at the previous edge.
  always @(posedge clock) begin
    raw[0] = key_up_n;
    raw[1] = key_down_n;
    raw[2] = key_start_n;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        m_state[d]  = S_IDLE;
        m_period[d] = DEF_P;
        m_start[d]  = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        m_hist0[k]  = 1'b1;
        m_hist1[k]  = 1'b1;
        m_lvl[k]    = 1'b1;
        m_pulse[k]  = 1'b0;
        m_streak[k] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_state[d] == S_IDLE) begin
          if (m_pulse[0] && !m_pulse[1])
            m_period[d] = (m_period[d] < 15) ? m_period[d] + 1 : 15;
          else if (m_pulse[1] && !m_pulse[0])
            m_period[d] = (m_period[d] > 1) ? m_period[d] - 1 : 1;
          if (m_pulse[2]) m_state[d] = S_RUN;
        end else if (m_state[d] == S_RUN) begin
          if (d == 0 && finished) m_state[d] = S_IDLE;
          else if (m_pulse[2])    m_state[d] = S_PAUSE;
        end else begin
          if (m_pulse[2]) m_state[d] = S_RUN;
        end
        m_start[d] = (m_state[d] == S_RUN);
      end
      for (int k = 0; k < 3; k++) begin
        bit dly;
        dly        = m_hist1[k];
        m_hist1[k] = m_hist0[k];
        m_hist0[k] = raw[k];
        m_pulse[k] = 1'b0;
        if (dly != m_lvl[k]) begin
          m_streak[k]++;
          if (m_streak[k] == DEB) begin
            m_lvl[k]    = dly;
            m_streak[k] = 0;
            m_pulse[k]  = !dly;
          end
        end else begin
          m_streak[k] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_a_period", int'(per_a),   m_period[0]);
      chk("m_a_start",  int'(start_a), int'(m_start[0]));
      chk("m_a_run",    int'(run_a),   int'(m_start[0]));
      chk("m_a_hex",    int'(hex_a),   int'(seg_ref[m_period[0]]));
      chk("m_b_period", int'(per_b),   m_period[1]);
      chk("m_b_start",  int'(start_b), int'(m_start[1]));
      chk("m_b_run",    int'(run_b),   int'(m_start[1]));
      chk("m_b_hex",    int'(hex_b),   int'(seg_ref[m_period[1]]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int k, input logic v);
    case (k)
      0:       key_up_n    = v;
      1:       key_down_n  = v;
      default: key_start_n = v;
    endcase
  endtask

  task automatic press(input int k, input int held);
    @(posedge clock); #2;
    drive(k, 1'b0);
    repeat (held) @(posedge clock);
    #2;
    drive(k, 1'b1);
    repeat (10) @(posedge clock);
    #2;
  endtask

  task automatic pulse_finished();
    @(posedge clock); #2;
    finished = 1'b1;
    @(posedge clock); #2;
    finished = 1'b0;
    repeat (2) @(posedge clock);
    #2;
  endtask

  initial begin
    seg_ref[0]  = 7'b1000000; seg_ref[1]  = 7'b1111001;
    seg_ref[2]  = 7'b0100100; seg_ref[3]  = 7'b0110000;
    seg_ref[4]  = 7'b0011001; seg_ref[5]  = 7'b0010010;
    seg_ref[6]  = 7'b0000010; seg_ref[7]  = 7'b1111000;
    seg_ref[8]  = 7'b0000000; seg_ref[9]  = 7'b0010000;
    seg_ref[10] = 7'b0001000; seg_ref[11] = 7'b0000011;
    seg_ref[12] = 7'b1000110; seg_ref[13] = 7'b0100001;
    seg_ref[14] = 7'b0000110; seg_ref[15] = 7'b0001110;

    tbl[0] = '{op: 0, reps: 3,  exp_period: 8,  exp_start: 0};
    tbl[1] = '{op: 0, reps: 12, exp_period: 15, exp_start: 0};
    tbl[2] = '{op: 1, reps: 16, exp_period: 1,  exp_start: 0};
    tbl[3] = '{op: 0, reps: 8,  exp_period: 9,  exp_start: 0};
    tbl[4] = '{op: 2, reps: 1,  exp_period: 9,  exp_start: 1};
    tbl[5] = '{op: 0, reps: 1,  exp_period: 9,  exp_start: 1};
    tbl[6] = '{op: 2, reps: 1,  exp_period: 9,  exp_start: 0};
    tbl[7] = '{op: 2, reps: 1,  exp_period: 9,  exp_start: 1};
    tbl[8] = '{op: 3, reps: 1,  exp_period: 9,  exp_start: 0};

    reset       = 1'b0;
    key_up_n    = 1'b1;
    key_down_n  = 1'b1;
    key_start_n = 1'b1;
    finished    = 1'b0;
    hold        = '{0, 0, 0};

    // reset low for two edges
    @(posedge clock); #2;
    chk_en = 1'b1;
    @(posedge clock); #2;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_period", int'(per_a),   5);
    chk("rst_start",  int'(start_a), 0);
    chk("rst_run",    int'(run_a),   0);
    chk("rst_hex",    int'(hex_a),   int'(7'b0010010));

    // directed table
    for (int i = 0; i < 9; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        if (tbl[i].op < 3) press(tbl[i].op, 10);
        else               pulse_finished();
      end
      @(negedge clock);
      chk($sformatf("tbl%0d_period", i), int'(per_a),   tbl[i].exp_period);
      chk($sformatf("tbl%0d_start", i),  int'(start_a), tbl[i].exp_start);
      chk($sformatf("tbl%0d_run", i),    int'(run_a),   tbl[i].exp_start);
      chk($sformatf("tbl%0d_hex", i),    int'(hex_a),   int'(seg_ref[tbl[i].exp_period]));
    end
    chk("b_ignores_finished", int'(start_b), 1);

    // bounce: low/high every 2 cycles never qualifies
    @(posedge clock); #2;
    for (int t = 0; t < 10; t++) begin
      key_start_n = ~key_start_n;
      repeat (2) @(posedge clock);
      #2;
    end
    key_start_n = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("bounce_start", int'(start_a), 0);

    // start latency: high exactly 7 edges after the raw edge
    @(posedge clock); #2;
    key_start_n = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("lat_edge6", int'(start_a), 0);
    @(posedge clock);
    @(negedge clock);
    chk("lat_edge7", int'(start_a), 1);
    repeat (3) @(posedge clock);
    #2;
    key_start_n = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("run_period9", int'(per_a), 9);

    // single-cycle reset mid-run
    @(posedge clock); #2;
    reset = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_period", int'(per_a),   5);
    chk("midrst_start",  int'(start_a), 0);
    chk("midrst_hex",    int'(hex_a),   int'(7'b0010010));

    // start press coincident with finished while running
    press(2, 10);
    @(negedge clock);
    chk("coinc_pre_start", int'(start_a), 1);
    @(posedge clock); #2;
    key_start_n = 1'b0;
    repeat (6) @(posedge clock);
    #2;
    finished = 1'b1;
    @(posedge clock); #2;
    finished = 1'b0;
    @(negedge clock);
    chk("coinc_start", int'(start_a), 0);
    chk("coinc_run",   int'(run_a),   0);
    @(posedge clock); #2;
    key_start_n = 1'b1;
    repeat (10) @(posedge clock);
    #2;
    press(0, 10);
    @(negedge clock);
    chk("coinc_idle_edit", int'(per_a), 6);

    // random phase
    for (int c = 0; c < 1500; c++) begin
      @(posedge clock); #2;
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          drive(k, ($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0);
          hold[k] = int'($urandom_range(1, 12));
        end else begin
          hold[k]--;
        end
      end
      finished = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 299) != 0);
    end
    @(posedge clock); #2;
    reset       = 1'b1;
    finished    = 1'b0;
    key_up_n    = 1'b1;
    key_down_n  = 1'b1;
    key_start_n = 1'b1;
    repeat (12) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/period_control.md
Name: period_control

Overview:
- Operator-input stage directly upstream of regressive_counter.
- Debounces three board push-buttons (KEY, active-low).
- Generates the seconds_period and start inputs that regressive_counter consumes.
- Shows the selected period on HEX4 and lights LEDR8 while a countdown runs.
- Consumes ledr9_finished to end a run in one-shot mode.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a key level is accepted (20 ms at 50 MHz). Benches override it with a small value.
- DEFAULT_PERIOD, 5: seconds_period value after reset. Legal range 1..15.
- ONE_SHOT, 1: 1 = a finished pulse while RUNNING returns the block to IDLE; 0 = ignore finished (counter auto-reloads).

Ports:
- clock, input, 1: system clock, 50 MHz.
- reset, input, 1: synchronous, active-low reset.
- key_up_n, input, 1: raw button, active-low; increments the period.
- key_down_n, input, 1: raw button, active-low; decrements the period.
- key_start_n, input, 1: raw button, active-low; start/pause toggle.
- finished, input, 1: from regressive_counter ledr9_finished.
- seconds_period, output, 4: period to regressive_counter.
- start, output, 1: run level to regressive_counter. 1 = count, 0 = hold.
- hex4_period, output, 7: active-low 7-seg image of seconds_period, hex digit 1..F, segment order {g,f,e,d,c,b,a}.
- ledr8_running, output, 1: high in the RUNNING state.

Behaviour:
- All state is sampled on the rising edge of clock.
- reset=0 at an edge applies reset. This takes priority over every other input.
- Reset values:
  - seconds_period = DEFAULT_PERIOD
  - start = 0
  - ledr8_running = 0
  - hex4_period = seg(DEFAULT_PERIOD); for 5 this is 7'b0010010
  - state = IDLE
  - debouncer levels = released
  - debounce counters = 0
  - synchronizers = 1
- Debounce, per key:
  - Raw input passes through a 2-FF synchronizer.
  - A counter increments while the synchronized value differs from the accepted level. It clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - A 1-cycle press pulse fires on the accepted 1->0 transition. Release produces no pulse.
  - Total latency: a raw edge held stable produces the press pulse DEBOUNCE_CYCLES+2 cycles later.
  - Bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- FSM states: IDLE, RUNNING, PAUSED. Outputs are registered and change on the edge after the pulse.
  - IDLE: start=0. start_press -> RUNNING. up/down presses edit the period.
  - RUNNING: start=1, ledr8_running=1. start_press -> PAUSED. If ONE_SHOT=1 and finished=1 -> IDLE.
  - PAUSED: start=0. start_press -> RUNNING.
  - Simultaneous start_press and finished in RUNNING: finished wins; go to IDLE.
- Period arithmetic:
  - Only in IDLE. up/down presses are ignored in RUNNING and PAUSED; the period is locked.
  - up: period+1, saturating at 15.
  - down: period-1, saturating at 1. 0 is never produced.
  - up and down pulses in the same cycle: no change.
- hex4_period is a registered decode of the current seconds_period. It updates in the same cycle as seconds_period.
- Reset asserted mid-run (RUNNING or PAUSED): next edge gives IDLE, start=0, period=DEFAULT_PERIOD. An in-progress debounce is discarded.
- Holding a key produces exactly one pulse; there is no auto-repeat.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2.
  - PERIOD_MIN=1 and PERIOD_MAX=15.
  - The 16-entry active-low 7-seg hex table as a function hex7seg(4-bit). regressive_counter reuses it for HEX5.
- One sub-module: key_debouncer.
  - Parameter DEBOUNCE_CYCLES.
  - Ports: clock, reset, key_n, level, press_pulse.
  - Instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, DEFAULT_PERIOD=5, 20 ns clock):
1. Reset low 2 cycles, then high -> seconds_period=5, start=0, ledr8_running=0, hex4_period=7'b0010010.
2. Press key_up_n for 10 cycles, then release, three times -> seconds_period=8. Twelve further up presses -> saturates at 15, hex4_period=7'b0001110 (F). Sixteen down presses -> saturates at 1, never 0.
3. key_start_n low for 10 cycles -> start=1 exactly 7 cycles after the raw edge (6-cycle press pulse + 1 registered). Second press -> start=0 (PAUSED). Third press -> start=1.
4. In RUNNING press key_up_n -> seconds_period unchanged. Pulse finished=1 for 1 cycle with ONE_SHOT=1 -> IDLE, start=0. Repeat with ONE_SHOT=0 -> stays RUNNING.
5. Toggle key_start_n low/high every 2 cycles for 20 cycles -> no press pulse, start stays 0.
6. Drive reset=0 for 1 cycle while RUNNING with period=9 -> next edge: period=5, start=0, IDLE. Also assert start_press and finished in the same cycle -> IDLE.
